// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared state encoding, default limits and frame-format helpers for the UART receiver
package uart_rx_pkg;
  typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_e;
  localparam int DEF_PRESCALE_MAX = 32;
  localparam int DEF_DATA_W_MAX = 9;
  function automatic logic [3:0] frame_len(input logic [3:0] data_len, input logic par_en,
                                           input logic stop_bits);
    return 4'd2 + data_len + {3'b0, par_en} + {3'b0, stop_bits};
  endfunction
  function automatic logic cfg_legal(input logic [15:0] prescale, input logic [3:0] data_len,
                                     input int pmax, input int dmax);
    return !prescale[0] && prescale >= 16'd4 && int'(prescale) <= pmax &&
           data_len >= 4'd5 && int'(data_len) <= dmax;
  endfunction
endpackage

// File: rtl/uart_rx_cfg_check.sv
// uart_rx_cfg_check: legality check and frame length of the raw config, consumed at activation
module uart_rx_cfg_check import uart_rx_pkg::*; #(
  parameter int PRESCALE_MAX = DEF_PRESCALE_MAX,
  parameter int DATA_W_MAX = DEF_DATA_W_MAX,
  localparam int PW = $clog2(PRESCALE_MAX) + 1
) (
  input  logic [PW-1:0] prescale,
  input  logic [3:0]    data_len,
  input  logic          par_en,
  input  logic          stop_bits,
  output logic          legal,
  output logic [3:0]    flen
);
  assign legal = cfg_legal(16'(prescale), data_len, PRESCALE_MAX, DATA_W_MAX);
  assign flen = uart_rx_pkg::frame_len(data_len, par_en, stop_bits);
endmodule

// File: rtl/uart_rx_oversample_counter.sv
// uart_rx_oversample_counter: per-bit edge counter and per-frame bit counter with decoded timing strobes
module uart_rx_oversample_counter import uart_rx_pkg::*; #(
  parameter int PRESCALE_MAX = DEF_PRESCALE_MAX,
  parameter int DATA_W_MAX = DEF_DATA_W_MAX,
  localparam int EDGE_W = $clog2(PRESCALE_MAX),
  localparam int BIT_W = 4
) (
  input  logic              clk_based_on_prescale,
  input  logic              asy_reset,
  input  logic              enable,
  input  logic [EDGE_W:0]   prescale,
  input  logic [3:0]        data_len,
  input  logic              par_en,
  input  logic              stop_bits,
  output logic [EDGE_W-1:0] edge_count,
  output logic [BIT_W-1:0]  bit_count,
  output logic              sample_stb,
  output logic              sample_last,
  output logic              bit_done,
  output logic              frame_done,
  output logic              cfg_err
);
  state_e state_q, state_d;
  logic [EDGE_W-1:0] edge_q, edge_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [EDGE_W:0] sh_prescale_q, sh_prescale_d;
  logic [3:0] sh_len_q, sh_len_d;
  logic cfg_err_q, cfg_err_d;
  logic legal, last_edge, last_bit, cnt;
  logic [3:0] flen;
  logic [EDGE_W:0] edge_x, mid;

  uart_rx_cfg_check #(.PRESCALE_MAX(PRESCALE_MAX), .DATA_W_MAX(DATA_W_MAX)) u_cfg (
    .prescale(prescale), .data_len(data_len), .par_en(par_en), .stop_bits(stop_bits),
    .legal(legal), .flen(flen)
  );

  assign edge_x = {1'b0, edge_q};
  assign mid = sh_prescale_q >> 1;
  assign last_edge = edge_x == sh_prescale_q - 1'b1;
  assign last_bit = bit_q == sh_len_q - 4'd1;

  always_ff @(posedge clk_based_on_prescale) begin
    if (!asy_reset) begin
      state_q <= IDLE;
      edge_q <= '0;
      bit_q <= '0;
      sh_prescale_q <= '0;
      sh_len_q <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      edge_q <= edge_d;
      bit_q <= bit_d;
      sh_prescale_q <= sh_prescale_d;
      sh_len_q <= sh_len_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // Counters default to zero so IDLE, HOLD and abort all clear them.
  always_comb begin
    state_d = state_q;
    edge_d = '0;
    bit_d = '0;
    sh_prescale_d = sh_prescale_q;
    sh_len_d = sh_len_q;
    cfg_err_d = enable & cfg_err_q;
    case (state_q)
      IDLE: if (enable) begin
        if (legal) begin
          state_d = COUNT;
          sh_prescale_d = prescale;
          sh_len_d = flen;
        end else cfg_err_d = 1'b1;
      end
      COUNT: if (!enable) state_d = IDLE;
      else begin
        edge_d = last_edge ? '0 : edge_q + 1'b1;
        bit_d = !last_edge ? bit_q : last_bit ? '0 : bit_q + 1'b1;
        state_d = last_edge && last_bit ? HOLD : COUNT;
      end
      HOLD: state_d = enable ? HOLD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt = state_q == COUNT;
    sample_stb = cnt && edge_x >= mid - 1'b1 && edge_x <= mid + 1'b1;
    sample_last = cnt && edge_x == mid + 1'b1;
    bit_done = cnt && last_edge;
    frame_done = cnt && last_edge && last_bit;
  end

  assign edge_count = edge_q;
  assign bit_count = bit_q;
  assign cfg_err = cfg_err_q;
endmodule

// File: tb/tb_uart_rx_oversample_counter.sv
// tb_uart_rx_oversample_counter: directed scoreboard bench against a cycles-since-activation model
module tb_uart_rx_oversample_counter;
  logic clk = 1'b0, rstn = 1'b0, en = 1'b0;
  logic [5:0] prescale = 6'd8;
  logic [3:0] data_len = 4'd8;
  logic par_en = 1'b0, stop_bits = 1'b0;
  logic [4:0] edge_count;
  logic [3:0] bit_count;
  logic sample_stb, sample_last, bit_done, frame_done, cfg_err;
  int checks = 0, errors = 0, n_fd = 0, n_sl = 0;
  logic [13:0] sb[$];
  bit m_act = 0, m_hold = 0, m_err = 0;
  int m_k = 0, m_p = 8, m_len = 10;

  always #5 clk = ~clk;

  uart_rx_oversample_counter dut (
    .clk_based_on_prescale(clk), .asy_reset(rstn), .enable(en), .prescale(prescale),
    .data_len(data_len), .par_en(par_en), .stop_bits(stop_bits), .edge_count(edge_count),
    .bit_count(bit_count), .sample_stb(sample_stb), .sample_last(sample_last),
    .bit_done(bit_done), .frame_done(frame_done), .cfg_err(cfg_err)
  );

  function automatic logic [13:0] model_out();
    int e, b, mid;
    e = m_act ? m_k % m_p : 0;
    b = m_act ? m_k / m_p : 0;
    mid = m_p / 2;
    return {5'(e), 4'(b), m_act && e >= mid - 1 && e <= mid + 1, m_act && e == mid + 1,
            m_act && e == m_p - 1, m_act && m_k == m_p * m_len - 1, m_err};
  endfunction

  function automatic logic [13:0] dut_out();
    return {edge_count, bit_count, sample_stb, sample_last, bit_done, frame_done, cfg_err};
  endfunction

  task automatic model_edge();
    if (!rstn || !en) begin
      m_act = 0; m_hold = 0; m_k = 0; m_err = 0;
    end else if (m_act) begin
      if (m_k == m_p * m_len - 1) begin m_act = 0; m_hold = 1; m_k = 0; end
      else m_k++;
    end else if (!m_hold) begin
      if (!prescale[0] && prescale >= 4 && prescale <= 32 && data_len >= 5 && data_len <= 9) begin
        m_act = 1; m_k = 0; m_p = int'(prescale); m_len = 2 + int'(data_len) + int'(par_en) + int'(stop_bits);
      end else m_err = 1;
    end
  endtask

  task automatic compare(input string tag);
    logic [13:0] exp, got;
    exp = sb.pop_front();
    got = dut_out();
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s t=%0t got edge=%0d bit=%0d flags=%b exp edge=%0d bit=%0d flags=%b",
             tag, $time, got[13:9], got[8:5], got[4:0], exp[13:9], exp[8:5], exp[4:0]);
    end
  endtask

  task automatic tick(input string tag);
    model_edge();
    sb.push_back(model_out());
    @(posedge clk);
    @(negedge clk);
    n_fd += int'(frame_done);
    n_sl += int'(sample_last);
    compare(tag);
  endtask

  task automatic run(input string tag, input int n);
    repeat (n) tick(tag);
  endtask

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  initial begin
    @(negedge clk);
    tick("reset");
    rstn = 1'b1;
    en = 1'b1; n_fd = 0; n_sl = 0;
    run("t1_frame", 86);
    check_val("t1_frame_done_cnt", n_fd, 1);
    check_val("t1_sample_last_cnt", n_sl, 10);
    en = 1'b0; tick("t1_off");
    prescale = 6'd16; data_len = 4'd9; par_en = 1'b1; stop_bits = 1'b1;
    en = 1'b1; n_fd = 0; n_sl = 0;
    run("t2_frame", 212);
    check_val("t2_frame_done_cnt", n_fd, 1);
    check_val("t2_sample_last_cnt", n_sl, 13);
    en = 1'b0; tick("t2_off");
    prescale = 6'd8; data_len = 4'd8; par_en = 1'b0; stop_bits = 1'b0;
    en = 1'b1; n_fd = 0;
    run("t3_run", 30);
    check_val("t3_bit_before_abort", int'(bit_count), 3);
    check_val("t3_edge_before_abort", int'(edge_count), 5);
    en = 1'b0; tick("t3_abort");
    check_val("t3_abort_no_frame_done", n_fd, 0);
    en = 1'b1; tick("t3_restart");
    check_val("t3_restart_pos", int'({bit_count, edge_count}), 0);
    run("t3_restart", 4);
    en = 1'b0; tick("t3_off");
    en = 1'b1; n_fd = 0;
    run("t4_old_cfg", 10);
    prescale = 6'd16; data_len = 4'd5;
    run("t4_old_cfg", 76);
    check_val("t4_old_frame_done_cnt", n_fd, 1);
    en = 1'b0; tick("t4_off");
    en = 1'b1; n_fd = 0; n_sl = 0;
    run("t4_new_cfg", 116);
    check_val("t4_new_frame_done_cnt", n_fd, 1);
    check_val("t4_new_sample_last_cnt", n_sl, 7);
    en = 1'b0; tick("t4_off2");
    prescale = 6'd7; en = 1'b1; tick("t5_p7");
    check_val("t5_err_p7", int'(cfg_err), 1);
    prescale = 6'd2; tick("t5_p2");
    prescale = 6'd8; data_len = 4'd4; tick("t5_dl4");
    check_val("t5_err_dl4", int'(cfg_err), 1);
    en = 1'b0; tick("t5_clear");
    check_val("t5_err_cleared", int'(cfg_err), 0);
    data_len = 4'd8; en = 1'b1;
    run("t6_run", 21);
    rstn = 1'b0; tick("t6_reset");
    rstn = 1'b1;
    run("t6_after_reset", 5);
    sb.push_back(model_out());
    #1 rstn = 1'b0;
    #2 rstn = 1'b1;
    #1 compare("t6_no_clock_reset");
    n_fd = 0;
    run("t6_hold", 100);
    check_val("t6_no_restart", n_fd, 1);
    en = 1'b0; tick("t6_off");
    en = 1'b1; run("t6_restart", 3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
